// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multicycle control FSM for the MIPS core. Sequences instruction fetch,
//   decode, execute, memory and writeback over a shared unified memory that
//   signals completion with mem_ready. Adds an optional memory-timeout bus
//   error and a retired-instruction counter.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-low reset
//   opcode, funct     IR[31:26] and IR[5:0]; stable after FETCH
//   zero              ALU zero flag for the current cycle (branch decision)
//   mem_ready         memory finishes the current access this cycle
//   pc_write, ir_write, iord, mem_read, mem_write, reg_write,
//   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src
//                     datapath controls, decoded from the current state
//   retire            one-cycle pulse when an instruction completes
//   illegal           one-cycle pulse for an undecodable opcode/funct
//   bus_err           one-cycle pulse when a memory access times out
//   instr_count       retired instruction count, wraps modulo 2^CNT_W
//
// Handshake: the memory is not valid/ready in both directions; the FSM
// holds its request (mem_read or mem_write, with iord) every cycle of a
// memory state, and the access completes in the cycle mem_ready is high.
// mem_ready is ignored in all other states.
module mips_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             retire,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_RWB,
    S_BRANCH, S_IMM_EX, S_IMM_WB, S_JUMP, S_JAL, S_JR, S_ILLEGAL
  } state_t;

  state_t             state, state_next;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_next;
  logic               waiting, timeout;

  // A memory state with no completion this cycle is a wait cycle.
  assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR))
                   && !mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && waiting
                   && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
  // Zero outside wait cycles, so every memory state is entered with a clear count.
  assign wait_cnt_next = (waiting && !timeout) ? wait_cnt + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    pc_src     = 2'b00;
    retire     = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;

    case (state)
      S_FETCH: begin
        // ALU computes PC + 4 while the instruction word is read.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_R:             state_next = (funct == FN_JR) ? S_JR : S_EXEC;
          OP_LW, OP_SW:     state_next = S_MEMADR;
          OP_BEQ, OP_BNE:   state_next = S_BRANCH;
          OP_ADDI, OP_SLTI: state_next = S_IMM_EX;
          OP_J:             state_next = S_JUMP;
          OP_JAL:           state_next = S_JAL;
          default:          state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        // A timed-out store must not write anything.
        mem_write = !timeout;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        state_next = S_RWB;
        case (funct)
          6'b100000: alu_op = ALU_ADD;
          6'b100010: alu_op = ALU_SUB;
          6'b100100: alu_op = ALU_AND;
          6'b100101: alu_op = ALU_OR;
          6'b101010: alu_op = ALU_SLT;
          default:   state_next = S_ILLEGAL;
        endcase
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'b01;
        pc_write   = (opcode == OP_BEQ) ? zero : !zero;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_IMM_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_next = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC already holds the return address (PC + 4) from FETCH.
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JR: begin
        pc_src     = 2'b11;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal    = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // Timeout abandons the access; PC is untouched, so FETCH retries.
    if (timeout) begin
      bus_err    = 1'b1;
      state_next = S_FETCH;
    end

    // A reset cycle aborts whatever is in flight: no side effects.
    if (!rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
      bus_err   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Instruction-level bench for mips_multicycle_ctrl. Each instruction is
//   expanded into its list of phases (fetch with waits, decode, execute,
//   memory, writeback); every phase contributes one expected control word
//   to exp_q, and a compare process checks the DUT outputs each cycle.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam int TMO   = 4;
  localparam int W     = 21 + CNT_W;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A,
                         OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3, A_SLT = 3'd4;
  // Write enables and pulses: suppressed in any reset cycle.
  localparam logic [20:0] GATE = 21'b110011_00_00_0_00_000_00_111;

  // Clock / reset / DUT
  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic alu_src_a, retire, illegal, bus_err;
  logic [2:0] alu_op;
  logic [CNT_W-1:0] instr_count;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .retire(retire),
    .illegal(illegal), .bus_err(bus_err), .instr_count(instr_count)
  );

  // Scoreboard state
  logic [W-1:0]     exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               cyc     = 0;
  logic [CNT_W-1:0] model_cnt = '0;
  logic             cur_rst;
  logic [5:0]       cur_op, cur_fn;
  logic [W-1:0]     act;

  assign act = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, retire, illegal,
                bus_err, instr_count};

  function automatic logic [20:0] cw(
    input logic pcw, input logic irw, input logic io, input logic mrd, input logic mwr,
    input logic rw, input logic [1:0] rd, input logic [1:0] m2r, input logic sa,
    input logic [1:0] sb, input logic [2:0] aop, input logic [1:0] ps,
    input logic ret, input logic ill, input logic be);
    return {pcw, irw, io, mrd, mwr, rw, rd, m2r, sa, sb, aop, ps, ret, ill, be};
  endfunction

  // kind 0 = instruction fetch, 1 = load data, 2 = store data
  function automatic logic [20:0] phase_w(input int kind, input logic rdy, input logic to);
    case (kind)
      0:       return cw(rdy, rdy, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b01, A_ADD, 2'b00, 0, 0, to);
      1:       return cw(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, A_ADD, 2'b00, 0, 0, to);
      default: return cw(0, 0, 1, 0, !to, 0, 2'b00, 2'b00, 0, 2'b00, A_ADD, 2'b00, rdy, 0, to);
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // R-type ALU operation; -1 marks an undecodable funct.
  function automatic int r_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return int'(A_ADD);
      6'h22:   return int'(A_SUB);
      6'h24:   return int'(A_AND);
      6'h25:   return int'(A_OR);
      6'h2A:   return int'(A_SLT);
      default: return -1;
    endcase
  endfunction

  // Driver: one clock cycle with its expected control word.
  task automatic step(input logic rdy, input logic z, input logic [20:0] ctl);
    @(negedge clk);
    rst = cur_rst; opcode = cur_op; funct = cur_fn; mem_ready = rdy; zero = z;
    if (!cur_rst) ctl = ctl & ~GATE;
    exp_q.push_back({ctl, model_cnt});
    if (!cur_rst) model_cnt = '0;
    else if (ctl[2]) model_cnt = model_cnt + 1'b1;
    cyc++;
  endtask

  task automatic mem_phase(input int kind, input int nwait, output logic to);
    logic rdy;
    to = 1'b0;
    for (int i = 0; i <= nwait; i++) begin
      rdy = (i == nwait);
      if (!rdy && i == TMO) begin
        to = 1'b1;
        step(1'b0, rbit(), phase_w(kind, 1'b0, 1'b1));
        break;
      end
      step(rdy, rbit(), phase_w(kind, rdy, 1'b0));
    end
  endtask

  task automatic do_reset(input int n);
    logic r;
    cur_rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      r = rbit();
      step(r, rbit(), phase_w(0, r, 1'b0));
    end
    cur_rst = 1'b1;
  endtask

  // zsel: 0 / 1 force zero in the branch cycle, anything else randomizes it.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel,
                           input int fw, input int mw, output int ncyc);
    int   start, a;
    logic to, z;
    start  = cyc;
    cur_op = op;
    cur_fn = fn;
    mem_phase(0, fw, to);
    while (to) mem_phase(0, 0, to);
    step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, A_ADD, 2'b00, 0, 0, 0));
    case (op)
      OP_R: begin
        a = r_alu(fn);
        if (fn == 6'h08)
          step(rbit(), rbit(), cw(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, A_ADD, 2'b11, 1, 0, 0));
        else begin
          step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00,
                                  (a < 0) ? A_ADD : 3'(a), 2'b00, 0, 0, 0));
          if (a < 0)
            step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, A_ADD, 2'b00, 0, 1, 0));
          else
            step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, A_ADD, 2'b00, 1, 0, 0));
        end
      end
      OP_LW, OP_SW: begin
        step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, A_ADD, 2'b00, 0, 0, 0));
        mem_phase((op == OP_LW) ? 1 : 2, mw, to);
        if (op == OP_LW && !to)
          step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, A_ADD, 2'b00, 1, 0, 0));
      end
      OP_BEQ, OP_BNE: begin
        z = (zsel == 0 || zsel == 1) ? (zsel == 1) : rbit();
        step(rbit(), z, cw((op == OP_BEQ) ? z : !z, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00,
                           A_SUB, 2'b01, 1, 0, 0));
      end
      OP_ADDI, OP_SLTI: begin
        step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10,
                                (op == OP_SLTI) ? A_SLT : A_ADD, 2'b00, 0, 0, 0));
        step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, A_ADD, 2'b00, 1, 0, 0));
      end
      OP_J:
        step(rbit(), rbit(), cw(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, A_ADD, 2'b10, 1, 0, 0));
      OP_JAL:
        step(rbit(), rbit(), cw(1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, A_ADD, 2'b10, 1, 0, 0));
      default:
        step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, A_ADD, 2'b00, 0, 1, 0));
    endcase
    ncyc = cyc - start;
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Compare process: every driven cycle, away from the rising edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL ctrl_word t=%0t op=%h fn=%h: got %h, expected %h (diff %h)",
                   $time, opcode, funct, act, e, act ^ e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int   n, fw, mw, sel;
    logic [5:0] op, fn;
    logic to;
    rst = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    cur_rst = 1'b0; cur_op = '0; cur_fn = '0;

    do_reset(2);
    step(1'b0, 1'b0, phase_w(0, 1'b0, 1'b0));
    #2;
    check_lit("reset_mem_read", int'(mem_read), 1);
    check_lit("reset_pc_write", int'(pc_write), 0);
    check_lit("reset_count", int'(instr_count), 0);
    // That fetch saw mem_ready = 0; reset again so the next fetch starts clean.
    do_reset(1);

    run_instr(OP_R, 6'h20, 2, 0, 0, n);  check_lit("add_cycles", n, 4);
    run_instr(OP_LW, 6'h00, 2, 0, 3, n); check_lit("lw_wait3_cycles", n, 8);
    run_instr(OP_SW, 6'h00, 2, 0, 0, n); check_lit("sw_cycles", n, 4);
    run_instr(OP_BEQ, 6'h00, 1, 0, 0, n); check_lit("beq_cycles", n, 3);
    run_instr(OP_BEQ, 6'h00, 0, 0, 0, n);
    run_instr(OP_BNE, 6'h00, 1, 0, 0, n);
    run_instr(OP_BNE, 6'h00, 0, 0, 0, n);
    run_instr(OP_R, 6'h08, 2, 0, 0, n);  check_lit("jr_cycles", n, 3);
    run_instr(OP_ADDI, 6'h00, 2, 0, 0, n); check_lit("addi_cycles", n, 4);
    run_instr(OP_R, 6'h20, 2, 5, 0, n);  check_lit("fetch_timeout_cycles", n, 9);
    run_instr(6'h3F, 6'h00, 2, 0, 0, n); check_lit("illegal_op_cycles", n, 3);
    run_instr(OP_R, 6'h3F, 2, 0, 0, n);  check_lit("illegal_fn_cycles", n, 4);
    run_instr(OP_SW, 6'h00, 2, 0, 6, n); check_lit("sw_timeout_cycles", n, 8);

    // Reset landing in the writeback cycle of an add.
    cur_op = OP_R; cur_fn = 6'h20;
    mem_phase(0, 0, to);
    step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, A_ADD, 2'b00, 0, 0, 0));
    step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, A_ADD, 2'b00, 0, 0, 0));
    cur_rst = 1'b0;
    step(rbit(), rbit(), cw(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, A_ADD, 2'b00, 1, 0, 0));
    do_reset(1);

    // Randomized instruction stream.
    for (int k = 0; k < 160; k++) begin
      sel = $urandom_range(0, 9);
      fn  = 6'($urandom_range(0, 63));
      case (sel)
        0, 1: begin
          op = OP_R;
          case ($urandom_range(0, 6))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
            4: fn = 6'h2A; 5: fn = 6'h08; default: ;
          endcase
        end
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_BEQ;
        5: op = OP_BNE;
        6: op = rbit() ? OP_ADDI : OP_SLTI;
        7: op = OP_J;
        8: op = OP_JAL;
        default: op = 6'($urandom_range(0, 63));
      endcase
      fw = ($urandom_range(0, 15) == 0) ? 5 : $urandom_range(0, 2);
      mw = ($urandom_range(0, 15) == 0) ? 5 : $urandom_range(0, 3);
      run_instr(op, fn, 2, fw, mw, n);
    end

    // Counter wrap at CNT_W = 4.
    do_reset(2);
    for (int k = 0; k < 15; k++) run_instr(OP_J, 6'h00, 2, 0, 0, n);
    @(posedge clk); #1;
    check_lit("count_15", int'(instr_count), 15);
    run_instr(OP_J, 6'h00, 2, 0, 0, n);
    @(posedge clk); #1;
    check_lit("count_wrap", int'(instr_count), 0);

    @(negedge clk);
    #3;
    check_lit("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
